// File: rtl/output_arbiter.sv
// output_arbiter: 4-input round-robin packet arbiter for one output port.
// A grant is held for a whole packet (no preemption), released on the last
// beat, on requester abort, or on timeout. One idle bubble between grants.
// Optional feature macro: ARB_TIMEOUT_EN enables the grant-hold timeout
// counter; without it timeout is tied low and grants are held indefinitely.
module output_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] last,
    input  logic       out_ready,
    output logic [3:0] gnt,
    output logic [1:0] mux_sel,
    output logic       arb_active,
    output logic       beat,
    output logic       pkt_done,
    output logic       abort_err,
    output logic       timeout
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t     state, state_nxt;
    logic [1:0] rr_ptr;
    logic [1:0] pick;
    logic       pick_vld;
    logic       release_gnt;

    // Grant-side outputs are all derived from the registered state/mux_sel.
    assign arb_active  = (state == XFER);
    assign gnt         = arb_active ? (4'b0001 << mux_sel) : 4'b0000;
    assign beat        = arb_active & out_ready;
    assign pkt_done    = beat & last[mux_sel];
    // Precedence: completion over timeout over abort.
    assign abort_err   = arb_active & ~req[mux_sel] & ~pkt_done & ~timeout;
    assign release_gnt = pkt_done | timeout | abort_err;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] hold_cnt;

    assign timeout = arb_active & ~pkt_done & (hold_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Hold counter: zero while idle so it starts at 0 on the first XFER cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else if (state == XFER)
            hold_cnt <= hold_cnt + 1'b1;
        else
            hold_cnt <= '0;
    end
`else
    assign timeout = 1'b0;

    // TIMEOUT_CYCLES only matters with the timeout feature; keep it referenced.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    // Round-robin search: first set req bit starting at rr_ptr, wrapping mod 4.
    always_comb begin
        pick     = rr_ptr;
        pick_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] idx;
            idx = rr_ptr + 2'(k);
            if (!pick_vld && req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: grant from IDLE on any request, release from XFER on
    // completion, timeout or abort.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_vld)    state_nxt = XFER;
            XFER: if (release_gnt) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Grant index is latched on arbitration and held through XFER and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mux_sel <= 2'd0;
        else if (state == IDLE && pick_vld)
            mux_sel <= pick;
    end

    // Round-robin pointer advances past the port whose grant just ended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= 2'd0;
        else if (state == XFER && release_gnt)
            rr_ptr <= mux_sel + 2'd1;
    end

endmodule

// File: tb/tb_output_arbiter.sv
// tb_output_arbiter: scoreboard bench for output_arbiter. Expected per-cycle
// outputs are computed from a behavioural model when inputs are driven,
// queued, and popped/compared when the DUT outputs are sampled.
module tb_output_arbiter;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, last;
    logic       out_ready;
    logic [3:0] gnt;
    logic [1:0] mux_sel;
    logic       arb_active, beat, pkt_done, abort_err, timeout;

    output_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last), .out_ready(out_ready),
        .gnt(gnt), .mux_sel(mux_sel), .arb_active(arb_active), .beat(beat),
        .pkt_done(pkt_done), .abort_err(abort_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       act;
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       beat;
        logic       done;
        logic       ab;
        logic       to;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] grants[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    // Reference model state.
    bit         m_act;
    logic [1:0] m_sel, m_rr;
    int         m_cnt;
    bit         prev_act;
    int         act_cycles, to_first, step_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_sel = 2'd0; m_rr = 2'd0; m_cnt = 0; prev_act = 0;
    endtask

    // One clock cycle: drive inputs, queue expected outputs, sample, compare,
    // then advance the model as the DUT will on the coming rising edge.
    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rdy);
        exp_t       e, o;
        logic [1:0] idx;
        bit         found;
        @(negedge clk);
        req = r; last = l; out_ready = rdy;
        e.act  = m_act;
        e.sel  = m_sel;
        e.gnt  = m_act ? 4'(1 << m_sel) : 4'b0;
        e.beat = m_act && rdy;
        e.done = e.beat && l[m_sel];
`ifdef ARB_TIMEOUT_EN
        e.to   = m_act && !e.done && (m_cnt == TO - 1);
`else
        e.to   = 1'b0;
`endif
        e.ab   = m_act && !r[m_sel] && !e.done && !e.to;
        exp_q.push_back(e);
        #2;
        o = {arb_active, mux_sel, gnt, beat, pkt_done, abort_err, timeout};
        e = exp_q.pop_front();
        check("cycle", 32'(o), 32'(e));
        if (arb_active && !prev_act) grants.push_back(mux_sel);
        prev_act = arb_active;
        if (arb_active) act_cycles++;
        if (timeout && to_first < 0) to_first = step_idx;
        step_idx++;
        if (!m_act) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                idx = m_rr + 2'(k);
                if (!found && r[idx]) begin found = 1; m_sel = idx; end
            end
            if (found) begin m_act = 1; m_cnt = 0; end
        end else if (e.done || e.to || e.ab) begin
            m_act = 0;
            m_rr  = m_sel + 2'd1;
        end else begin
            m_cnt++;
        end
    endtask

    // Assert reset mid-cycle (inputs left as they are) and check outputs drop at once.
    task automatic do_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_outs", 32'({arb_active, mux_sel, gnt, beat, pkt_done, abort_err, timeout}), 32'd0);
        model_reset();
        @(negedge clk);
        req = 4'b0; last = 4'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0; last = 4'b0; out_ready = 1'b0;
        model_reset();
        to_first = -1; act_cycles = 0; step_idx = 0;
        #12;
        check("rst_init", 32'({arb_active, mux_sel, gnt, beat, pkt_done, abort_err, timeout}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Port 2, three beats, last on the third; then an idle cycle.
        step(4'b0100, 4'b0000, 1'b1);
        step(4'b0100, 4'b0000, 1'b1);
        step(4'b0100, 4'b0000, 1'b1);
        step(4'b0100, 4'b0100, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        // rr_ptr now 3: with everyone requesting, port 3 must win.
        grants.delete();
        step(4'b1111, 4'b1111, 1'b1);
        step(4'b1111, 4'b1111, 1'b1);
        check("rr_after_p2", 32'(grants.size() > 0 ? grants[0] : 2'd0), 32'd3);

        // Rotation 0,1,2,3,0 from reset with single-beat packets.
        do_reset();
        grants.delete();
        for (int i = 0; i < 10; i++) step(4'b1111, 4'b1111, 1'b1);
        check("rot_cnt", 32'(grants.size()), 32'd5);
        for (int i = 0; i < 5 && i < grants.size(); i++)
            check("rot_sel", 32'(grants[i]), 32'(i % 4));

        // Port 1 aborts after two beats; next search starts at port 2.
        do_reset();
        step(4'b0010, 4'b0000, 1'b1);
        step(4'b0010, 4'b0000, 1'b1);
        step(4'b0010, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        grants.delete();
        step(4'b1011, 4'b0000, 1'b0);
        step(4'b1011, 4'b0000, 1'b0);
        check("abort_next", 32'(grants.size() > 0 ? grants[0] : 2'd0), 32'd3);

        // Port 0 stalled with last high, completes on the first ready cycle.
        do_reset();
        step(4'b0001, 4'b0001, 1'b0);
        for (int i = 0; i < 5; i++) step(4'b0001, 4'b0001, 1'b0);
        step(4'b0001, 4'b0001, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);

        // Reset during beat 2 of a port-3 packet, then req=1001 -> port 0.
        do_reset();
        step(4'b1000, 4'b0000, 1'b1);
        step(4'b1000, 4'b0000, 1'b1);
        do_reset();
        grants.delete();
        step(4'b1001, 4'b0000, 1'b1);
        step(4'b1001, 4'b0000, 1'b1);
        check("rst_first", 32'(grants.size() > 0 ? grants[0] : 2'd3), 32'd0);

        // Long stall: timeout in the 8th XFER cycle, or grant held throughout.
        do_reset();
        act_cycles = 0; to_first = -1; step_idx = 0;
        for (int i = 0; i < 120; i++) step(4'b0001, 4'b0000, 1'b0);
`ifdef ARB_TIMEOUT_EN
        check("to_first", 32'(to_first), 32'd8);
`else
        check("persist", 32'(act_cycles), 32'd119);
`endif

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++)
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
